// File: rtl/walk_unit.sv
// Two-level translation table walker.
// Accepts a walk request (VA, ASID, table base), fetches the first-level
// descriptor and, for coarse-table entries, the second-level descriptor, then
// either writes a TLB entry or reports a translation fault.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_walk_req/va/asid      walk request; o_walk_ready high when idle
//   o_walk_done/o_fault     completion pulse, fault flag, o_fault_level (0=L1, 1=L2)
//   i_ttb, i_abort          table base (bits [31:14]), cancel current walk
//   o_mem_req/addr          descriptor fetch, held until i_mem_ack; i_mem_rdata
//   o_tlb_*                 TLB fill fields, qualified by o_tlb_write
module walk_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_walk_req,
    input  logic [31:0] i_walk_va,
    input  logic [7:0]  i_walk_asid,
    output logic        o_walk_ready,
    output logic        o_walk_done,
    output logic        o_fault,
    output logic        o_fault_level,
    input  logic [31:0] i_ttb,
    input  logic        i_abort,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_tlb_write,
    output logic [31:0] o_tlb_va,
    output logic [1:0]  o_tlb_type,
    output logic [19:0] o_tlb_pa,
    output logic [3:0]  o_tlb_domin,
    output logic [7:0]  o_tlb_asid,
    output logic [7:0]  o_tlb_ap,
    output logic        o_tlb_apx
);

    typedef enum logic [2:0] {StIdle, StL1, StL2, StWrite, StFault, StDrain} state_t;

    state_t      state;
    logic [31:0] walk_va;
    logic [7:0]  walk_asid;
    logic [21:0] l2_base;
    logic [3:0]  l2_domain;
    logic        abort_flag;
    // Set when reset lands on an outstanding fetch: a late ack may still arrive.
    logic        drain_flag;

    logic unused_bits;
    assign unused_bits = ^{i_ttb[13:0], i_mem_rdata[3:2]};

    // While reset is held the unit reports ready; after release a pending drain
    // holds off new requests until the stray ack window has passed.
    assign o_walk_ready = (state == StIdle) && (i_rst || !drain_flag);
    assign o_tlb_write  = (state == StWrite) && !i_abort;
    assign o_walk_done  = ((state == StWrite) || (state == StFault)) && !i_abort;
    assign o_fault      = (state == StFault) && !i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= StIdle;
            drain_flag    <= drain_flag | o_mem_req;
            walk_va       <= '0;
            walk_asid     <= '0;
            l2_base       <= '0;
            l2_domain     <= '0;
            abort_flag    <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_fault_level <= 1'b0;
            o_tlb_va      <= '0;
            o_tlb_type    <= '0;
            o_tlb_pa      <= '0;
            o_tlb_domin   <= '0;
            o_tlb_asid    <= '0;
            o_tlb_ap      <= '0;
            o_tlb_apx     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (drain_flag) begin
                        state      <= StDrain;
                        drain_flag <= 1'b0;
                    end else if (i_walk_req) begin
                        state      <= StL1;
                        walk_va    <= i_walk_va;
                        walk_asid  <= i_walk_asid;
                        abort_flag <= 1'b0;
                        o_mem_req  <= 1'b1;
                        o_mem_addr <= {i_ttb[31:14], i_walk_va[31:20], 2'b00};
                    end
                end
                StL1: begin
                    if (i_abort) abort_flag <= 1'b1;
                    if (i_mem_ack) begin
                        if (abort_flag || i_abort) begin
                            state     <= StIdle;
                            o_mem_req <= 1'b0;
                        end else begin
                            unique case (i_mem_rdata[1:0])
                                2'b01: begin
                                    state      <= StL2;
                                    l2_base    <= i_mem_rdata[31:10];
                                    l2_domain  <= i_mem_rdata[8:5];
                                    o_mem_addr <= {i_mem_rdata[31:10], walk_va[19:12], 2'b00};
                                end
                                2'b10: begin
                                    state       <= StWrite;
                                    o_mem_req   <= 1'b0;
                                    o_tlb_va    <= walk_va;
                                    o_tlb_asid  <= walk_asid;
                                    o_tlb_ap    <= {i_mem_rdata[11:10], 6'h00};
                                    o_tlb_apx   <= i_mem_rdata[15];
                                    // Bit 18 selects a 16MB supersection over a 1MB section.
                                    if (i_mem_rdata[18]) begin
                                        o_tlb_type  <= 2'd0;
                                        o_tlb_pa    <= {i_mem_rdata[31:24], 12'h000};
                                        o_tlb_domin <= 4'h0;
                                    end else begin
                                        o_tlb_type  <= 2'd1;
                                        o_tlb_pa    <= {i_mem_rdata[31:20], 8'h00};
                                        o_tlb_domin <= i_mem_rdata[8:5];
                                    end
                                end
                                default: begin
                                    state         <= StFault;
                                    o_mem_req     <= 1'b0;
                                    o_fault_level <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                StL2: begin
                    if (i_abort) abort_flag <= 1'b1;
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (abort_flag || i_abort) begin
                            state <= StIdle;
                        end else if (i_mem_rdata[1:0] == 2'b00) begin
                            state         <= StFault;
                            o_fault_level <= 1'b1;
                        end else begin
                            state       <= StWrite;
                            o_tlb_va    <= walk_va;
                            o_tlb_asid  <= walk_asid;
                            o_tlb_domin <= l2_domain;
                            o_tlb_ap    <= i_mem_rdata[11:4];
                            o_tlb_apx   <= 1'b0;
                            if (i_mem_rdata[1:0] == 2'b01) begin
                                o_tlb_type <= 2'd2;
                                o_tlb_pa   <= {i_mem_rdata[31:16], 4'h0};
                            end else begin
                                o_tlb_type <= 2'd3;
                                o_tlb_pa   <= i_mem_rdata[31:12];
                            end
                        end
                    end
                end
                StWrite, StFault, StDrain: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_walk_unit.sv
module tb_walk_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_walk_req = 1'b0;
    logic [31:0] i_walk_va = '0;
    logic [7:0]  i_walk_asid = '0;
    logic        o_walk_ready, o_walk_done, o_fault, o_fault_level;
    logic [31:0] i_ttb = '0;
    logic        i_abort = 1'b0;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_tlb_write;
    logic [31:0] o_tlb_va;
    logic [1:0]  o_tlb_type;
    logic [19:0] o_tlb_pa;
    logic [3:0]  o_tlb_domin;
    logic [7:0]  o_tlb_asid;
    logic [7:0]  o_tlb_ap;
    logic        o_tlb_apx;

    walk_unit dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_walk_req(i_walk_req), .i_walk_va(i_walk_va), .i_walk_asid(i_walk_asid),
        .o_walk_ready(o_walk_ready), .o_walk_done(o_walk_done), .o_fault(o_fault),
        .o_fault_level(o_fault_level), .i_ttb(i_ttb), .i_abort(i_abort),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_tlb_write(o_tlb_write), .o_tlb_va(o_tlb_va),
        .o_tlb_type(o_tlb_type), .o_tlb_pa(o_tlb_pa), .o_tlb_domin(o_tlb_domin),
        .o_tlb_asid(o_tlb_asid), .o_tlb_ap(o_tlb_ap), .o_tlb_apx(o_tlb_apx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        fault;
        logic        level;
        logic [1:0]  typ;
        logic [19:0] pa;
        logic [3:0]  dom;
        logic [7:0]  ap;
        logic        apx;
        logic [31:0] va;
        logic [7:0]  asid;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference walk computed from descriptor formats with plain arithmetic.
    task automatic ref_walk(input logic [31:0] ttb, input logic [31:0] va, input logic [7:0] asid,
                            input logic [31:0] d1, input logic [31:0] d2, output exp_t e,
                            output logic [31:0] a1, output logic [31:0] a2, output bit l2);
        e = '0;
        e.va = va;
        e.asid = asid;
        l2 = 0;
        a1 = (ttb & 32'hFFFF_C000) | ((va >> 20) << 2);
        a2 = (d1 & 32'hFFFF_FC00) | (((va >> 12) & 32'hFF) << 2);
        case (d1 % 4)
            1: begin
                l2 = 1;
                e.dom = 4'((d1 >> 5) & 15);
                case (d2 % 4)
                    0: begin e.fault = 1; e.level = 1; end
                    1: begin e.typ = 2; e.pa = 20'((d2 >> 16) << 4); end
                    default: begin e.typ = 3; e.pa = 20'(d2 >> 12); end
                endcase
                e.ap = 8'((d2 >> 4) & 255);
            end
            2: begin
                if (((d1 >> 18) & 1) == 1) begin
                    e.typ = 0; e.pa = 20'((d1 >> 24) << 12); e.dom = 0;
                end else begin
                    e.typ = 1; e.pa = 20'((d1 >> 20) << 8); e.dom = 4'((d1 >> 5) & 15);
                end
                e.ap = 8'(((d1 >> 10) & 3) << 6);
                e.apx = 1'((d1 >> 15) & 1);
            end
            default: begin e.fault = 1; e.level = 0; end
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_walk_ready && n < 20) begin tick(); n++; end
        chk("ready_wait", 128'(o_walk_ready), 128'(1));
    endtask

    // Present one descriptor fetch: check request/address, hold for dly cycles, ack.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data, input int dly,
                         input bit abort_wait, input bit abort_ack, input bit busy);
        chk("mem_req", {o_mem_req, o_mem_addr}, {1'b1, addr});
        if (abort_wait) i_abort = 1'b1;
        for (int i = 0; i < dly; i++) begin
            if (busy) begin i_walk_req = 1'b1; i_walk_va = $urandom; end
            tick();
            i_abort = 1'b0;
            chk("mem_hold", {o_mem_req, o_mem_addr}, {1'b1, addr});
        end
        i_walk_req = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_rdata = data;
        if (abort_ack) i_abort = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        i_mem_rdata = $urandom;
        i_abort = 1'b0;
    endtask

    // abort_mode: 0 none, 1 while L1 outstanding, 2 with L1 ack, 3 while L2 outstanding,
    // 4 in the result cycle.
    task automatic do_walk(input logic [31:0] ttb, input logic [31:0] va, input logic [7:0] asid,
                           input logic [31:0] d1, input logic [31:0] d2, input int dly1,
                           input int dly2, input int abort_mode, input bit busy);
        exp_t e;
        logic [31:0] a1, a2;
        bit l2, fetch_abort;
        ref_walk(ttb, va, asid, d1, d2, e, a1, a2, l2);
        fetch_abort = (abort_mode == 1) || (abort_mode == 2) || (abort_mode == 3 && l2);
        wait_ready();
        if (!fetch_abort && abort_mode != 4) exp_q.push_back(e);
        i_walk_req = 1'b1; i_walk_va = va; i_walk_asid = asid; i_ttb = ttb;
        tick();
        i_walk_req = 1'b0; i_walk_va = $urandom; i_walk_asid = 8'($urandom); i_ttb = $urandom;
        serve(a1, d1, dly1, abort_mode == 1, abort_mode == 2, busy);
        if (l2 && abort_mode != 1 && abort_mode != 2)
            serve(a2, d2, dly2, abort_mode == 3, 1'b0, busy);
        if (fetch_abort) begin
            chk("abort_idle", {o_walk_ready, o_mem_req}, {1'b1, 1'b0});
        end else if (abort_mode == 4) begin
            i_abort = 1'b1;
        end else begin
            chk("latency", 128'(o_walk_done), 128'(1));
        end
        tick();
        i_abort = 1'b0;
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (!i_rst && (o_walk_done || o_tlb_write)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {o_walk_done, o_tlb_write}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.fault)
                    chk("fault_result", {o_walk_done, o_fault, o_fault_level, o_tlb_write},
                        {1'b1, 1'b1, e.level, 1'b0});
                else
                    chk("tlb_result",
                        {o_walk_done, o_fault, o_tlb_write, o_tlb_type, o_tlb_pa, o_tlb_domin,
                         o_tlb_ap, o_tlb_apx, o_tlb_va, o_tlb_asid},
                        {1'b1, 1'b0, 1'b1, e.typ, e.pa, e.dom, e.ap, e.apx, e.va, e.asid});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("reset_state",
            {o_walk_ready, o_mem_req, o_tlb_write, o_walk_done, o_fault, o_fault_level,
             o_tlb_va, o_tlb_type, o_tlb_pa, o_tlb_domin, o_tlb_asid, o_tlb_ap, o_tlb_apx},
            {1'b1, 5'b0, 32'h0, 2'h0, 20'h0, 4'h0, 8'h0, 8'h0, 1'b0});
        i_rst = 1'b0;
        tick();

        // Section, coarse table -> small page, L1 fault, L2 fault.
        do_walk(32'h0000_4000, 32'h1234_5678, 8'h5A, 32'h8760_0C22, 32'h0, 0, 0, 0, 0);
        do_walk(32'h0000_4000, 32'h1234_5678, 8'h3C, 32'h0010_0041, 32'hABCD_EFF2, 0, 0, 0, 0);
        do_walk(32'h0000_4000, 32'h1234_5678, 8'h11, 32'h0000_0000, 32'h0, 0, 0, 0, 0);
        chk("tlb_hold", 128'(o_tlb_pa), 128'(20'hABCDE));
        do_walk(32'h0000_4000, 32'h1234_5678, 8'h22, 32'h0010_0041, 32'h0000_0000, 1, 2, 0, 0);
        // Abort during L1 with a 3-cycle ack delay, with requests ignored meanwhile.
        do_walk(32'h0000_4000, 32'h1234_5678, 8'h33, 32'h8760_0C22, 32'h0, 3, 0, 1, 1);

        // Reset while the L2 fetch is outstanding, then a stray ack after release.
        wait_ready();
        i_walk_req = 1'b1; i_walk_va = 32'h1234_5678; i_ttb = 32'h0000_4000;
        tick();
        i_walk_req = 1'b0;
        serve(32'h0000_448C, 32'h0010_0041, 0, 1'b0, 1'b0, 1'b0);
        chk("l2_outstanding", {o_mem_req, o_mem_addr}, {1'b1, 32'h0010_0114});
        i_rst = 1'b1;
        tick();
        chk("reset_mid_walk", {o_mem_req, o_walk_ready, o_tlb_write, o_walk_done}, 4'b0100);
        i_rst = 1'b0;
        tick();
        i_mem_ack = 1'b1; i_mem_rdata = 32'hABCD_EFF2;
        tick();
        i_mem_ack = 1'b0;
        tick();
        chk("ready_after_reset", {o_walk_ready, o_mem_req}, 2'b10);

        // Randomised walks across all descriptor kinds, delays and abort points.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] d1;
            int kind, mode;
            d1 = $urandom;
            kind = $urandom_range(0, 4);
            case (kind)
                0: d1[1:0] = 2'b00;
                1: d1[1:0] = 2'b11;
                2: begin d1[1:0] = 2'b10; d1[18] = 1'b0; end
                3: begin d1[1:0] = 2'b10; d1[18] = 1'b1; end
                default: d1[1:0] = 2'b01;
            endcase
            mode = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 4);
            do_walk($urandom, $urandom, 8'($urandom), d1, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), mode, 1'($urandom));
        end

        repeat (4) tick();
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/walk_unit.md
WALK_UNIT -- requirements
Module: walk_unit

Interface
Parameters: none.
REQ-001 SHALL have ports: i_clk  in  1  clock; i_rst  in  1  reset, synchronous, active-high; clock i_clk.
REQ-002 SHALL have walk request ports: i_walk_req in 1 start walk; i_walk_va in 32 faulting VA; i_walk_asid in 8 ASID; o_walk_ready out 1 idle/accepting.
REQ-003 SHALL have walk result ports: o_walk_done out 1 completion pulse; o_fault out 1 translation fault; o_fault_level out 1 (0=L1, 1=L2).
REQ-004 SHALL have ports: i_ttb in 32 table base, bits [31:14] used; i_abort in 1 cancel walk.
REQ-005 SHALL have memory ports: o_mem_req out 1; o_mem_addr out 32; i_mem_ack in 1; i_mem_rdata in 32, valid with i_mem_ack.
REQ-006 SHALL have TLB-fill ports: o_tlb_write 1; o_tlb_va 32; o_tlb_type 2 (0 supersection, 1 section, 2 large, 3 small); o_tlb_pa 20 (PA[31:12]); o_tlb_domin 4; o_tlb_asid 8; o_tlb_ap 8 (AP[11:4]); o_tlb_apx 1.

Function
REQ-007 SHALL implement states IDLE, L1, L2, WRITE, FAULT, DRAIN.
REQ-008 In IDLE o_walk_ready=1; i_walk_req=1 latches i_walk_va/i_walk_asid/i_ttb, clears the abort flag, goes to L1; i_walk_req ignored in all other states.
REQ-009 L1: o_mem_req=1, o_mem_addr={ttb[31:14], va[31:20], 2'b00}; o_mem_req and o_mem_addr SHALL stay stable until the i_mem_ack cycle.
REQ-010 On L1 ack, decode rdata[1:0]: 00/11 -> FAULT, level 0; 10 with bit18=1 -> WRITE, type 0, pa={rdata[31:24],12'h000}, domain 0; 10 with bit18=0 -> WRITE, type 1, pa={rdata[31:20],8'h00}, domain rdata[8:5]; 01 -> L2, latching domain rdata[8:5] and coarse base rdata[31:10].
REQ-011 Section/supersection: ap={rdata[11:10],6'h00}, apx=rdata[15].
REQ-012 L2: o_mem_addr={base[31:10], va[19:12], 2'b00}, same hold rule. On ack: 00 -> FAULT, level 1; 01 -> WRITE, type 2, pa={rdata[31:16],4'h0}; 1x -> WRITE, type 3, pa=rdata[31:12]; both with ap=rdata[11:4], apx=0.
REQ-013 WRITE: o_tlb_write=1 and o_walk_done=1 for exactly one cycle, o_fault=0, o_tlb_va=latched VA, o_tlb_asid=latched ASID; then IDLE.
REQ-014 FAULT: o_walk_done=1, o_fault=1, o_fault_level valid for one cycle, o_tlb_write=0; then IDLE.
REQ-015 Minimum latency with same-cycle ack: acceptance at edge N; L1 req cycle N+1; write/done cycle N+2 (section) or N+3 (page).
REQ-016 i_abort=1 in L1/L2 SHALL set a sticky abort flag; the outstanding request SHALL stay held until ack; on ack go to IDLE with no write and no done. If i_abort coincides with ack, same result.
REQ-017 i_abort in WRITE/FAULT SHALL suppress o_tlb_write and o_walk_done that cycle; state goes to IDLE.
REQ-018 DRAIN is entered only when reset deasserts while the memory bus may still hold an ack; it SHALL be unused otherwise and exit to IDLE after one cycle.
REQ-019 o_tlb_* fields SHALL be held from the decode cycle until the next walk decode; only o_tlb_write qualifies them.

Reset
REQ-020 i_rst SHALL, on the next clock edge, force IDLE and clear o_mem_req, o_tlb_write, o_walk_done, o_fault, o_fault_level, the abort flag, and all o_tlb_* fields; o_walk_ready=1.
REQ-021 Reset mid-walk SHALL drop o_mem_req immediately and never produce o_tlb_write or o_walk_done for that walk.

Verification
REQ-022 ttb=0x00004000, va=0x12345678, L1 addr 0x0000448C returns 0x87600C22 -> o_tlb_write, type 1, pa=0x87600, domin 1, ap=0xC0, apx 0, asid echoed.
REQ-023 Same va, L1 returns 0x00100041 -> L2 addr 0x00100114; L2 returns 0xABCDEFF2 -> type 3, pa=0xABCDE, domin 2, ap=0xFF.
REQ-024 L1 returns 0x00000000 -> o_walk_done=1, o_fault=1, level 0, no o_tlb_write; L2 returns 0x0 -> level 1.
REQ-025 i_abort during L1 with ack delayed 3 cycles -> o_mem_req held 3 cycles, then IDLE, no write, no done.
REQ-026 i_rst in L2 with request outstanding -> o_mem_req=0 next cycle, o_walk_ready=1, no write ever; i_walk_req during a walk is ignored.
